// File: rtl/score_digits_drawer_pkg.sv
// Shared types and the seven-segment decode for the score digit drawer.
package score_pkg;

    // Segment order is {a, b, c, d, e, f, g}, so bit 6 is segment a.
    typedef logic [6:0] seg_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ADDING = 1'b1
    } state_t;

    function automatic seg_t bcd_to_seg(input logic [3:0] digit);
        seg_t seg;
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/score_digits_drawer_bcd_counter.sv
// Multi-digit BCD incrementer that holds at all nines; clear wins over enable.
module bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] next_value;
    logic                all_nine;

    always_comb begin
        logic carry;
        next_value = value;
        all_nine   = 1'b1;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] != 4'd9) begin
                all_nine = 1'b0;
            end
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    next_value[4*i +: 4] = 4'd0;
                end else begin
                    next_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= '0;
        end else if (en && !all_nine) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/score_digits_drawer.sv
// Score keeper plus seven-segment renderer feeding the "number box" layer of the objects mux.
// state  | meaning
// IDLE   | ready for an add request
// ADDING | counting the latched amount into the score, one per cycle
module score_digits_drawer
    import score_pkg::*;
#(
    parameter int         TOP_LEFT_X  = 16,
    parameter int         TOP_LEFT_Y  = 16,
    parameter int         DIGITS      = 4,
    parameter int         DIGIT_W     = 16,
    parameter int         DIGIT_H     = 32,
    parameter int         GAP         = 4,
    parameter int         SEG_T       = 3,
    parameter logic [7:0] DIGIT_COLOR = 8'hFC
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [10:0]           pixelX,
    input  logic [10:0]           pixelY,
    input  logic                  addValid,
    input  logic [7:0]            addAmount,
    output logic                  addReady,
    input  logic                  clearScore,
    output logic [4*DIGITS-1:0]   scoreBCD,
    output logic                  numberDrawingRequest,
    output logic [7:0]            numberRGB
);

    localparam int PITCH = DIGIT_W + GAP;
    localparam int BOX_W = DIGITS * PITCH - GAP;
    localparam int MID   = DIGIT_H / 2;

    localparam logic [10:0] TLX_L      = 11'(TOP_LEFT_X);
    localparam logic [10:0] TLY_L      = 11'(TOP_LEFT_Y);
    localparam logic [10:0] BOX_W_L    = 11'(BOX_W);
    localparam logic [10:0] DIGIT_W_L  = 11'(DIGIT_W);
    localparam logic [10:0] DIGIT_H_L  = 11'(DIGIT_H);
    localparam logic [10:0] SEG_T_L    = 11'(SEG_T);
    localparam logic [10:0] RIGHT_L    = 11'(DIGIT_W - SEG_T);
    localparam logic [10:0] BOTTOM_L   = 11'(DIGIT_H - SEG_T);
    localparam logic [10:0] MID_L      = 11'(MID);
    localparam logic [10:0] G_TOP_L    = 11'(MID - 1);
    localparam logic [10:0] G_BOT_L    = 11'(MID - 1 + SEG_T);

    state_t              state;
    logic [7:0]          remain;
    logic [4*DIGITS-1:0] shadow;
    logic                inc_en;

    assign inc_en = (state == ADDING) && !clearScore;

    bcd_counter #(.DIGITS(DIGITS)) u_counter (
        .clk   (clk),
        .reset (resetN),
        .clear (clearScore),
        .en    (inc_en),
        .value (scoreBCD)
    );

    always_ff @(posedge clk) begin
        if (resetN) begin
            state    <= IDLE;
            remain   <= 8'd0;
            addReady <= 1'b1;
        end else if (clearScore) begin
            state    <= IDLE;
            remain   <= 8'd0;
            addReady <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (addValid && addReady) begin
                        remain <= addAmount;
                        if (addAmount != 8'd0) begin
                            state    <= ADDING;
                            addReady <= 1'b0;
                        end
                    end
                end
                ADDING: begin
                    remain <= remain - 8'd1;
                    if (remain == 8'd1) begin
                        state    <= IDLE;
                        addReady <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    addReady <= 1'b1;
                end
            endcase
        end
    end

    // Sampling the register before its update gives the pre-increment value on a coincident edge.
    always_ff @(posedge clk) begin
        if (resetN) begin
            shadow <= '0;
        end else if (startOfFrame) begin
            shadow <= scoreBCD;
        end
    end

    logic [10:0] lx, ly, cx;
    logic        in_box, lit;
    logic [3:0]  nibble;
    seg_t        segs, region;

    always_comb begin
        int  k_sel;
        logic mid_col, left_col, right_col, top_half;
        lx     = pixelX - TLX_L;
        ly     = pixelY - TLY_L;
        in_box = (pixelX >= TLX_L) && (pixelY >= TLY_L) && (lx < BOX_W_L) && (ly < DIGIT_H_L);

        // Compare ladder instead of a divider: the last threshold passed picks the cell.
        k_sel = 0;
        cx    = lx;
        for (int i = 1; i < DIGITS; i++) begin
            if (lx >= 11'(i * PITCH)) begin
                k_sel = i;
                cx    = lx - 11'(i * PITCH);
            end
        end

        nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (k_sel == i) begin
                nibble = shadow[4*(DIGITS-1-i) +: 4];
            end
        end
        segs = bcd_to_seg(nibble);

        mid_col   = (cx >= SEG_T_L) && (cx < RIGHT_L);
        left_col  = (cx < SEG_T_L);
        right_col = (cx >= RIGHT_L);
        top_half  = (ly < MID_L);
        region = {
            mid_col && (ly < SEG_T_L),
            right_col && top_half,
            right_col && !top_half,
            mid_col && (ly >= BOTTOM_L),
            left_col && !top_half,
            left_col && top_half,
            mid_col && (ly >= G_TOP_L) && (ly < G_BOT_L)
        };

        lit = in_box && (cx < DIGIT_W_L) && |(segs & region);
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            numberDrawingRequest <= 1'b0;
            numberRGB            <= 8'h00;
        end else begin
            numberDrawingRequest <= lit;
            numberRGB            <= lit ? DIGIT_COLOR : 8'h00;
        end
    end

endmodule

// File: tb/tb_score_digits_drawer.sv
// Bench for score_digits_drawer: integer score model checked every cycle plus directed literal checks.
module tb_score_digits_drawer;

    logic        clk = 1'b0;
    logic        resetN, startOfFrame, addValid, clearScore;
    logic [10:0] pixelX, pixelY;
    logic [7:0]  addAmount;
    logic        addReady;
    logic [15:0] scoreBCD;
    logic        numberDrawingRequest;
    logic [7:0]  numberRGB;

    score_digits_drawer dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .addValid             (addValid),
        .addAmount            (addAmount),
        .addReady             (addReady),
        .clearScore           (clearScore),
        .scoreBCD             (scoreBCD),
        .numberDrawingRequest (numberDrawingRequest),
        .numberRGB            (numberRGB)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which segments each decimal digit lights, as letters.
    string pats [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic bit has_seg(input string p, input byte ch);
        for (int i = 0; i < p.len(); i++) if (p[i] == ch) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_lit(input int x, input int y, input int shown);
        int lx, ly, k, cx, dig, div;
        string p;
        bit mid;
        if (x < 16 || y < 16) return 1'b0;
        lx = x - 16;
        ly = y - 16;
        if (lx >= 76 || ly >= 32) return 1'b0;
        k  = lx / 20;
        cx = lx % 20;
        if (cx >= 16) return 1'b0;
        div = 1;
        for (int i = 0; i < 3 - k; i++) div = div * 10;
        dig = (shown / div) % 10;
        p   = pats[dig];
        mid = (cx >= 3) && (cx < 13);
        return (mid && ly < 3 && has_seg(p, "a")) ||
               (mid && ly >= 29 && has_seg(p, "d")) ||
               (mid && ly >= 15 && ly < 18 && has_seg(p, "g")) ||
               (cx < 3 && ly < 16 && has_seg(p, "f")) ||
               (cx >= 13 && ly < 16 && has_seg(p, "b")) ||
               (cx < 3 && ly >= 16 && has_seg(p, "e")) ||
               (cx >= 13 && ly >= 16 && has_seg(p, "c"));
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    int   m_score = 0, m_shadow = 0, m_remain = 0;
    bit   m_busy = 0, m_ready = 1, m_req = 0, m_valid = 0;

    always @(posedge clk) begin
        if (resetN) begin
            m_score = 0; m_shadow = 0; m_remain = 0;
            m_busy = 0; m_req = 0; m_valid = 1;
        end else begin
            bit nreq;
            nreq = model_lit(int'(pixelX), int'(pixelY), m_shadow);
            if (startOfFrame) m_shadow = m_score;
            if (clearScore) begin
                m_score = 0; m_busy = 0; m_remain = 0;
            end else if (m_busy) begin
                if (m_score < 9999) m_score++;
                m_remain--;
                if (m_remain == 0) m_busy = 0;
            end else if (addValid && m_ready) begin
                m_remain = int'(addAmount);
                m_busy   = (addAmount != 0);
            end
            m_req = nreq;
        end
        m_ready = !m_busy;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_score", 32'(scoreBCD), 32'(to_bcd(m_score)));
            check("cyc_ready", 32'(addReady), 32'(m_ready));
            check("cyc_req",   32'(numberDrawingRequest), 32'(m_req));
            check("cyc_rgb",   32'(numberRGB), m_req ? 32'hFC : 32'h0);
        end
    end

    task automatic do_add(input int amt, output int low);
        addValid  = 1'b1;
        addAmount = 8'(amt);
        @(negedge clk);
        addValid = 1'b0;
        low = 0;
        while (addReady !== 1'b1 && low < 300) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    task automatic pix(input string name, input int x, input int y, input bit exp);
        pixelX = 11'(x);
        pixelY = 11'(y);
        @(negedge clk);
        check({name, "_req"}, 32'(numberDrawingRequest), 32'(exp));
        check({name, "_rgb"}, 32'(numberRGB), exp ? 32'hFC : 32'h0);
        pixelX = 11'd0;
        pixelY = 11'd0;
    endtask

    initial begin
        int low;
        resetN = 1'b1; startOfFrame = 1'b0; addValid = 1'b0; clearScore = 1'b0;
        pixelX = 11'd0; pixelY = 11'd0; addAmount = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_score", 32'(scoreBCD), 32'h0);
        check("rst_ready", 32'(addReady), 32'h1);
        check("rst_req",   32'(numberDrawingRequest), 32'h0);
        check("rst_rgb",   32'(numberRGB), 32'h0);
        resetN = 1'b0;
        @(negedge clk);

        pix("zero_seg_a", 20, 17, 1'b1);

        do_add(37, low);
        check("add37_busy", 32'(low), 32'd37);
        check("add37_score", 32'(scoreBCD), 32'h0037);
        sof();
        pix("d1_g_center", 44, 31, 1'b0);
        pix("d1_f_edge",   37, 31, 1'b1);
        pix("d3_g_row",    84, 31, 1'b0);
        pix("d3_seg_a",    84, 17, 1'b1);
        pix("left_out",    15, 16, 1'b0);
        pix("right_out",   95, 16, 1'b0);
        pix("right_edge",  92, 16, 1'b0);
        pix("last_col",    91, 16, 1'b1);
        pix("gap",         32, 17, 1'b0);
        pix("bottom_row",  20, 47, 1'b1);
        pix("below_box",   20, 48, 1'b0);

        do_add(0, low);
        check("add0_busy",  32'(low), 32'd0);
        check("add0_score", 32'(scoreBCD), 32'h0037);

        clearScore = 1'b1;
        @(negedge clk);
        clearScore = 1'b0;
        check("clear_score", 32'(scoreBCD), 32'h0);

        for (int i = 0; i < 39; i++) do_add(255, low);
        do_add(50, low);
        check("pre_sat", 32'(scoreBCD), 32'h9995);
        do_add(10, low);
        check("sat_busy",  32'(low), 32'd10);
        check("sat_score", 32'(scoreBCD), 32'h9999);
        sof();
        pix("nine_g", 24, 31, 1'b1);
        pix("nine_e", 17, 40, 1'b0);

        clearScore = 1'b1;
        @(negedge clk);
        clearScore = 1'b0;
        addValid = 1'b1; addAmount = 8'd200;
        @(negedge clk);
        addValid = 1'b0;
        repeat (49) @(negedge clk);
        check("mid_add_busy", 32'(addReady), 32'h0);
        clearScore = 1'b1; addValid = 1'b1; addAmount = 8'd5;
        @(negedge clk);
        clearScore = 1'b0; addValid = 1'b0;
        check("abort_score", 32'(scoreBCD), 32'h0);
        check("abort_ready", 32'(addReady), 32'h1);
        @(negedge clk);
        check("abort_hold", 32'(scoreBCD), 32'h0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
